// File: rtl/aemb2_ipfq.sv
`timescale 1ns/1ps
// aeMB2 instruction prefetch queue: a single-outstanding Wishbone fetcher that fills
// a small circular buffer of {pc, instruction} pairs consumed by the decode stage.
module aemb2_ipfq #(
    parameter int unsigned AEMB_IWB = 32,
    parameter int unsigned AEMB_PFQ = 2,
    parameter int unsigned AEMB_RST = 0
) (
    input  logic                gclk,
    input  logic                grst,
    output logic [AEMB_IWB-1:2] iwb_adr_o,
    output logic                iwb_stb_o,
    output logic                iwb_cyc_o,
    output logic [3:0]          iwb_sel_o,
    output logic                iwb_wre_o,
    input  logic                iwb_ack_i,
    input  logic [31:0]         iwb_dat_i,
    input  logic                bra_ex,
    input  logic [AEMB_IWB-1:2] bpc_ex,
    input  logic                iena,
    output logic                fet_vld,
    output logic [31:0]         fet_ins,
    output logic [AEMB_IWB-1:2] fet_pc,
    output logic [AEMB_PFQ:0]   fet_lvl
);

    localparam int unsigned DEPTH = 1 << AEMB_PFQ;

    typedef logic [AEMB_IWB-1:2] adr_t;
    typedef logic [AEMB_PFQ-1:0] ptr_t;
    typedef logic [AEMB_PFQ:0]   lvl_t;

    localparam adr_t RST_ADR  = adr_t'(AEMB_RST);
    localparam lvl_t LVL_FULL = lvl_t'(DEPTH);

    adr_t        adr_q, adr_d;
    adr_t        bpc_q, bpc_d;
    logic        stb_q, stb_d;
    logic        dsc_q, dsc_d;
    logic        run_q;
    ptr_t        wp_q, wp_d;
    ptr_t        rp_q, rp_d;
    lvl_t        lvl_q, lvl_d;

    adr_t        pc_mem  [DEPTH];
    logic [31:0] ins_mem [DEPTH];

    logic        ack;
    logic        pop;
    logic        push;
    logic        stb_go;
    lvl_t        lvl_pop;

    assign ack     = stb_q & iwb_ack_i;
    assign pop     = iena & fet_vld & ~bra_ex;
    assign push    = ack & ~dsc_q & ~bra_ex;
    assign lvl_pop = lvl_q - lvl_t'(pop);
    // run_q holds off the first strobe until the second edge after reset release
    assign stb_go  = ~stb_q & ~bra_ex & run_q & (lvl_pop != LVL_FULL);

    always_comb begin
        adr_d = adr_q;
        bpc_d = bpc_q;
        stb_d = stb_q;
        dsc_d = dsc_q;
        if (stb_q) begin
            if (ack) begin
                stb_d = 1'b0;
                dsc_d = 1'b0;
                if (bra_ex) begin
                    adr_d = bpc_ex;
                end else if (dsc_q) begin
                    adr_d = bpc_q;
                end else begin
                    adr_d = adr_q + adr_t'(1);
                end
            end else if (bra_ex) begin
                // bus cycle must finish on the old address; remember where to go next
                dsc_d = 1'b1;
                bpc_d = bpc_ex;
            end
        end else begin
            if (bra_ex) begin
                adr_d = bpc_ex;
            end
            stb_d = stb_go;
        end
    end

    always_comb begin
        wp_d  = wp_q + ptr_t'(push);
        rp_d  = rp_q + ptr_t'(pop);
        lvl_d = lvl_q + lvl_t'(push) - lvl_t'(pop);
        if (bra_ex) begin
            wp_d  = '0;
            rp_d  = '0;
            lvl_d = '0;
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            adr_q <= RST_ADR;
            bpc_q <= RST_ADR;
            stb_q <= 1'b0;
            dsc_q <= 1'b0;
            run_q <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            adr_q <= adr_d;
            bpc_q <= bpc_d;
            stb_q <= stb_d;
            dsc_q <= dsc_d;
            run_q <= 1'b1;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge gclk) begin
        if (push) begin
            pc_mem[wp_q]  <= adr_q;
            ins_mem[wp_q] <= iwb_dat_i;
        end
    end

    assign iwb_adr_o = adr_q;
    assign iwb_stb_o = stb_q;
    assign iwb_cyc_o = stb_q;
    assign iwb_sel_o = 4'hF;
    assign iwb_wre_o = 1'b0;

    assign fet_lvl = lvl_q;
    assign fet_vld = (lvl_q != '0);
    assign fet_pc  = fet_vld ? pc_mem[rp_q] : '0;
    assign fet_ins = fet_vld ? ins_mem[rp_q] : '0;

endmodule

// File: tb/tb_aemb2_ipfq.sv
`timescale 1ns/1ps
// Directed bench for aemb2_ipfq: a wait-state Wishbone slave model plus a queue of
// expected fetch addresses that is checked as entries are popped from the DUT.
module tb_aemb2_ipfq;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic [29:0] iwb_adr_o;
    logic        iwb_stb_o;
    logic        iwb_cyc_o;
    logic [3:0]  iwb_sel_o;
    logic        iwb_wre_o;
    logic        iwb_ack_i = 1'b0;
    logic [31:0] iwb_dat_i = 32'h0;
    logic        bra_ex = 1'b0;
    logic [29:0] bpc_ex = 30'h0;
    logic        iena = 1'b0;
    logic        fet_vld;
    logic [31:0] fet_ins;
    logic [29:0] fet_pc;
    logic [2:0]  fet_lvl;

    aemb2_ipfq #(
        .AEMB_IWB(32),
        .AEMB_PFQ(2),
        .AEMB_RST(32'h100)
    ) dut (
        .gclk     (gclk),
        .grst     (grst),
        .iwb_adr_o(iwb_adr_o),
        .iwb_stb_o(iwb_stb_o),
        .iwb_cyc_o(iwb_cyc_o),
        .iwb_sel_o(iwb_sel_o),
        .iwb_wre_o(iwb_wre_o),
        .iwb_ack_i(iwb_ack_i),
        .iwb_dat_i(iwb_dat_i),
        .bra_ex   (bra_ex),
        .bpc_ex   (bpc_ex),
        .iena     (iena),
        .fet_vld  (fet_vld),
        .fet_ins  (fet_ins),
        .fet_pc   (fet_pc),
        .fet_lvl  (fet_lvl)
    );

    initial forever #5 gclk = ~gclk;

    int          n_err = 0;
    int          n_chk = 0;
    int          wait_n = 0;
    int          cnt = 0;
    int          stb_seen;
    logic [29:0] sb [$];
    logic [29:0] bus_log [$];

    function automatic logic [31:0] ins_of(input logic [29:0] pc);
        return {2'b10, pc} ^ 32'h1234_5678;
    endfunction

    // Wishbone slave: acks after wait_n idle strobe cycles, data derived from address.
    initial forever begin
        @(posedge gclk);
        #1;
        if (iwb_ack_i) begin
            iwb_ack_i = 1'b0;
            cnt = 0;
        end else if (iwb_stb_o) begin
            if (cnt >= wait_n) begin
                iwb_ack_i = 1'b1;
                iwb_dat_i = ins_of(iwb_adr_o);
                bus_log.push_back(iwb_adr_o);
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge gclk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_from(input logic [29:0] base);
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back(base + 30'(i));
    endtask

    task automatic wait_vld(input string tag);
        for (int i = 0; i < 40 && !fet_vld; i++) tick();
        check(tag, 32'(fet_vld), 32'd1);
    endtask

    task automatic pop_one(input string tag);
        logic [29:0] exp_pc;
        exp_pc = sb.pop_front();
        check({tag, "_vld"}, 32'(fet_vld), 32'd1);
        check({tag, "_pc"}, 32'(fet_pc), 32'(exp_pc));
        check({tag, "_ins"}, fet_ins, ins_of(exp_pc));
        iena = 1'b1;
        tick();
        iena = 1'b0;
    endtask

    initial begin
        // Reset state
        #3 grst = 1'b0;
        tick();
        tick();
        check("rst_stb", 32'(iwb_stb_o), 32'd0);
        check("rst_cyc", 32'(iwb_cyc_o), 32'd0);
        check("rst_adr", 32'(iwb_adr_o), 32'h100);
        check("rst_lvl", 32'(fet_lvl), 32'd0);
        check("rst_vld", 32'(fet_vld), 32'd0);
        check("rst_ins", fet_ins, 32'd0);
        check("rst_pc", 32'(fet_pc), 32'd0);
        check("rst_sel", 32'(iwb_sel_o), 32'hF);
        check("rst_wre", 32'(iwb_wre_o), 32'd0);

        // Fill from reset address, zero wait states, no consumer
        grst = 1'b1;
        expect_from(30'h100);
        tick();
        check("rel_stb_e1", 32'(iwb_stb_o), 32'd0);
        tick();
        check("rel_stb_e2", 32'(iwb_stb_o), 32'd1);
        check("rel_adr_e2", 32'(iwb_adr_o), 32'h100);
        repeat (6) tick();
        check("fill_lvl3", 32'(fet_lvl), 32'd3);
        tick();
        check("fill_lvl4", 32'(fet_lvl), 32'd4);
        stb_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (iwb_stb_o) stb_seen++;
        end
        check("full_no_stb", 32'(stb_seen), 32'd0);
        check("full_lvl", 32'(fet_lvl), 32'd4);
        check("fill_nbus", 32'(bus_log.size()), 32'd4);
        check("fill_bus0", 32'(bus_log[0]), 32'h100);
        check("fill_bus3", 32'(bus_log[3]), 32'h103);

        // One pop from full restarts fetching at the next address
        pop_one("pop100");
        check("refetch_stb", 32'(iwb_stb_o), 32'd1);
        check("refetch_adr", 32'(iwb_adr_o), 32'h104);
        check("refetch_lvl", 32'(fet_lvl), 32'd3);
        tick();
        check("refill_lvl", 32'(fet_lvl), 32'd4);

        // Branch while a slow transaction is outstanding
        wait_n = 3;
        pop_one("pop101");
        check("pend_stb", 32'(iwb_stb_o), 32'd1);
        check("pend_adr", 32'(iwb_adr_o), 32'h105);
        check("pend_ack", 32'(iwb_ack_i), 32'd0);
        bra_ex = 1'b1;
        bpc_ex = 30'h200;
        tick();
        bra_ex = 1'b0;
        expect_from(30'h200);
        check("fl_lvl", 32'(fet_lvl), 32'd0);
        check("fl_vld", 32'(fet_vld), 32'd0);
        check("fl_pc", 32'(fet_pc), 32'd0);
        check("fl_ins", fet_ins, 32'd0);
        check("fl_stb_hold", 32'(iwb_stb_o), 32'd1);
        check("fl_adr_hold", 32'(iwb_adr_o), 32'h105);
        for (int i = 0; i < 20 && !iwb_ack_i; i++) tick();
        check("fl_wait_ack", 32'(iwb_ack_i), 32'd1);
        check("fl_ack_adr", 32'(iwb_adr_o), 32'h105);
        wait_n = 0;
        tick();
        check("dsc_stb", 32'(iwb_stb_o), 32'd0);
        check("dsc_adr", 32'(iwb_adr_o), 32'h200);
        check("dsc_lvl", 32'(fet_lvl), 32'd0);
        tick();
        check("new_stb", 32'(iwb_stb_o), 32'd1);
        check("new_adr", 32'(iwb_adr_o), 32'h200);
        wait_vld("wait_200");
        check("first_pc", 32'(fet_pc), 32'h200);

        // Push and pop in the same cycle at level 2
        for (int i = 0; i < 20 && !(fet_lvl == 3'd2 && iwb_ack_i); i++) tick();
        check("lvl2_ack", 32'(fet_lvl == 3'd2 && iwb_ack_i), 32'd1);
        pop_one("pop200");
        check("pp_lvl", 32'(fet_lvl), 32'd2);
        check("pp_head", 32'(fet_pc), 32'(sb[0]));

        // Branch coinciding with an ack
        for (int i = 0; i < 20 && !iwb_ack_i; i++) tick();
        check("co_wait_ack", 32'(iwb_ack_i), 32'd1);
        bra_ex = 1'b1;
        bpc_ex = 30'h40;
        tick();
        bra_ex = 1'b0;
        expect_from(30'h40);
        check("co_lvl", 32'(fet_lvl), 32'd0);
        check("co_stb", 32'(iwb_stb_o), 32'd0);
        check("co_adr", 32'(iwb_adr_o), 32'h40);
        iena = 1'b1;
        tick();
        iena = 1'b0;
        check("empty_pop_lvl", 32'(fet_lvl), 32'd0);
        check("co_new_stb", 32'(iwb_stb_o), 32'd1);
        check("co_new_adr", 32'(iwb_adr_o), 32'h40);
        for (int k = 0; k < 6; k++) begin
            wait_vld("drain_vld");
            pop_one("drain");
        end

        // Back-to-back branches during an outstanding cycle: the last one wins
        wait_n = 4;
        for (int i = 0; i < 20 && !(iwb_stb_o && !iwb_ack_i); i++) tick();
        check("rb_pend", 32'(iwb_stb_o && !iwb_ack_i), 32'd1);
        bra_ex = 1'b1;
        bpc_ex = 30'h300;
        tick();
        bpc_ex = 30'h310;
        tick();
        bra_ex = 1'b0;
        expect_from(30'h310);
        for (int i = 0; i < 20 && !iwb_ack_i; i++) tick();
        check("rb_wait_ack", 32'(iwb_ack_i), 32'd1);
        wait_n = 0;
        tick();
        check("rb_adr", 32'(iwb_adr_o), 32'h310);
        check("rb_stb", 32'(iwb_stb_o), 32'd0);
        check("rb_lvl", 32'(fet_lvl), 32'd0);
        wait_vld("rb_vld");
        pop_one("pop310");

        // Reset in the middle of an outstanding cycle
        wait_n = 5;
        for (int i = 0; i < 20 && !(iwb_stb_o && !iwb_ack_i); i++) tick();
        check("mr_pend", 32'(iwb_stb_o && !iwb_ack_i), 32'd1);
        grst = 1'b0;
        #1;
        check("mr_stb_async", 32'(iwb_stb_o), 32'd0);
        check("mr_cyc_async", 32'(iwb_cyc_o), 32'd0);
        check("mr_adr", 32'(iwb_adr_o), 32'h100);
        check("mr_lvl", 32'(fet_lvl), 32'd0);
        tick();
        tick();
        wait_n = 0;
        grst = 1'b1;
        expect_from(30'h100);
        tick();
        check("mr_stb_e1", 32'(iwb_stb_o), 32'd0);
        tick();
        check("mr_stb_e2", 32'(iwb_stb_o), 32'd1);
        check("mr_adr_e2", 32'(iwb_adr_o), 32'h100);
        wait_vld("mr_vld");
        pop_one("mr_pop100");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
